// File: rtl/priority_8x3.sv
// 8-to-3 priority encoder (highest index wins) with a masked request vector,
// combinational result path and an enable-loaded registered copy.
module priority_8x3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic [7:0] mask,
    input  logic       en,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] onehot,
    output logic [2:0] code_q,
    output logic       valid_q,
    output logic [7:0] onehot_q
);

    logic [7:0] req;

    assign req = in & mask;

    // Ascending scan: the last set bit seen is the highest index, so it wins.
    always_comb begin
        code  = 3'b000;
        valid = |req;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                code = 3'(i);
            end
        end
        onehot = valid ? (8'b0000_0001 << code) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= 3'b000;
            valid_q  <= 1'b0;
            onehot_q <= 8'h00;
        end else if (en) begin
            code_q   <= code;
            valid_q  <= valid;
            onehot_q <= onehot;
        end
    end

endmodule

// File: tb/tb_priority_8x3.sv
// Scoreboard bench for priority_8x3: directed and random stimulus against an
// arithmetic reference model; registered outputs checked by a separate monitor.
module tb_priority_8x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic [7:0] mask;
    logic       en;
    logic [2:0] code;
    logic       valid;
    logic [7:0] onehot;
    logic [2:0] code_q;
    logic       valid_q;
    logic [7:0] onehot_q;

    typedef struct {
        logic [2:0] c;
        logic       v;
        logic [7:0] oh;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   n_cmp = 0;
    int   n_bad = 0;

    priority_8x3 dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .mask     (mask),
        .en       (en),
        .code     (code),
        .valid    (valid),
        .onehot   (onehot),
        .code_q   (code_q),
        .valid_q  (valid_q),
        .onehot_q (onehot_q)
    );

    always #5 clk = ~clk;

    // Highest set bit found as floor(log2(in & mask)).
    function automatic exp_t ref_model(input logic [7:0] i, input logic [7:0] m);
        exp_t e;
        int   r;
        int   n;
        r = int'(i & m);
        n = 0;
        e.v = (r != 0);
        while (r > 1) begin
            r = r / 2;
            n++;
        end
        e.c  = n[2:0];
        e.oh = e.v ? 8'(2 ** n) : 8'h00;
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (in=%h mask=%h en=%b rst=%b) at %0t",
                     name, act, req, in, mask, en, rst, $time);
        end
    endtask

    task automatic check_regs(input string name, input exp_t e);
        check({name, ".code_q"},   8'(code_q),  8'(e.c));
        check({name, ".valid_q"},  8'(valid_q), 8'(e.v));
        check({name, ".onehot_q"}, onehot_q,    e.oh);
    endtask

    // Drive one cycle at the falling edge, check the combinational path, and
    // queue what the registers must hold after the next rising edge.
    task automatic cycle(input logic [7:0] i, input logic [7:0] m, input logic e, input logic r);
        exp_t x;
        @(negedge clk);
        in   = i;
        mask = m;
        en   = e;
        rst  = r;
        #1;
        x = ref_model(i, m);
        check("code",   8'(code),  8'(x.c));
        check("valid",  8'(valid), 8'(x.v));
        check("onehot", onehot,    x.oh);
        if (r) begin
            held = '{3'b000, 1'b0, 8'h00};
        end else if (e) begin
            held = x;
        end
        q.push_back(held);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_regs("reg", e);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] sweep [5];
        sweep = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h80};
        held = '{3'b000, 1'b0, 8'h00};
        rst  = 1'b1;
        in   = 8'h00;
        mask = 8'hFF;
        en   = 1'b1;
        #1;
        check_regs("reset", '{3'b000, 1'b0, 8'h00});

        cycle(8'h55, 8'hFF, 1'b1, 1'b1);
        foreach (sweep[k]) cycle(sweep[k], 8'hFF, 1'b1, 1'b0);

        cycle(8'h81, 8'hFF, 1'b1, 1'b0);
        cycle(8'h26, 8'hFF, 1'b1, 1'b0);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        cycle(8'hC0, 8'h7F, 1'b1, 1'b0);
        cycle(8'h80, 8'h7F, 1'b1, 1'b0);

        cycle(8'h10, 8'hFF, 1'b1, 1'b0);
        repeat (4) cycle(8'h02, 8'hFF, 1'b0, 1'b0);

        // Reset asserted between edges clears registers without a clock edge.
        cycle(8'hF0, 8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async_rst", '{3'b000, 1'b0, 8'h00});
        held = '{3'b000, 1'b0, 8'h00};
        cycle(8'h08, 8'hFF, 1'b1, 1'b0);
        cycle(8'h08, 8'hFF, 1'b0, 1'b0);

        for (int v = 0; v < 256; v++) cycle(8'(v), 8'hFF, 1'b1, 1'b0);

        repeat (400) begin
            cycle(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 30) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/priority_8x3.md
Name: priority_8x3

Overview:
- 8-input to 3-bit priority encoder; the highest-index asserted input bit wins.
- Combinational result path (code, valid, onehot) for same-cycle use.
- Registered copy of the result for pipelined consumers, with a load enable and a per-bit input mask.
- Used wherever a request vector must be reduced to the index of its most significant active request.

Parameters:
- None. Widths are fixed: 8-bit input, 3-bit code.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in  input  8  request vector; bit 7 has highest priority, bit 0 lowest
- mask  input  8  per-bit enable; bit i participates only when mask[i]=1 (tie to 8'hFF for plain encoding)
- en  input  1  load enable for the registered outputs
- code  output  3  combinational index of the winning bit
- valid  output  1  combinational; 1 when at least one unmasked bit is set
- onehot  output  8  combinational; only the winning bit set, all zero when none
- code_q  output  3  registered code
- valid_q  output  1  registered valid
- onehot_q  output  8  registered onehot

Behaviour:
- Effective request vector: req = in AND mask.
- code = index of the highest set bit of req.
  - req=8'b00000001 -> 3'b000
  - req=8'b00000100 -> 3'b010
  - req=8'b00010000 -> 3'b100
  - req=8'b01000000 -> 3'b110
  - req=8'b1xxxxxxx -> 3'b111
- Multiple bits set: the highest index wins, e.g. 8'b00100110 -> 3'b101.
- req all zero: code=3'b000, valid=0, onehot=8'h00.
  - code=000 alone is ambiguous between "bit 0" and "none"; consumers must qualify it with valid.
- valid = OR-reduction of req.
- onehot = 8'b1 shifted left by code when valid=1, else 8'h00.
- Combinational outputs:
  - Zero latency; they settle within the same delta/cycle as in/mask.
  - No dependence on clk or rst.
  - No latches; outputs fully defined for all 256×256 in/mask combinations, including X-free output when in/mask are known.
- Registered outputs:
  - On rising clk with en=1: code_q<=code, valid_q<=valid, onehot_q<=onehot (1-cycle latency).
  - en=0: hold previous values.
- Reset:
  - rst=1 asynchronously forces code_q=3'b000, valid_q=0, onehot_q=8'h00, regardless of clk/en.
  - Combinational outputs are unaffected by rst.
  - Deassertion takes effect on the next rising clk with en=1.
- Reset mid-operation: registered state is lost immediately; the first load after release captures the current combinational result.
- Simultaneous en=1 and rst=1: reset dominates.

Test Plan:
- Single-bit sweep, mask=8'hFF: in=8'b00000001, 00000100, 00010000, 01000000, 10000000 -> code=000, 010, 100, 110, 111 with valid=1 and onehot=in, all combinationally; with en=1, code_q matches one clk later.
- Priority: in=8'b10000001 -> code=111, onehot=8'h80; in=8'b00100110 -> code=101, onehot=8'h20.
- Zero and mask: in=8'h00 -> code=000, valid=0, onehot=00; in=8'hC0 with mask=8'h7F -> code=110, onehot=8'h40; in=8'h80 with mask=8'h7F -> valid=0.
- Enable hold: load in=8'h10 (code_q=100), set en=0, change in to 8'h02 -> code_q stays 100 for multiple cycles while code=001.
- Async reset: with valid_q=1, assert rst between clock edges -> code_q=000, valid_q=0, onehot_q=00 immediately; release rst with en=1, in=8'h08 -> next edge gives code_q=011.
- Exhaustive: all 256 in values with mask=8'hFF compared against a reference model for code/valid/onehot.
